shr_pipe: RTL and testbench

//  Parametrised, pipelined barrel shifter; successor to the combinational shr datapath component.

---
 rtl/shr_pkg.sv | 19 +
 rtl/shr_pipe_if.sv | 29 ++
 rtl/shr_pipe_stage.sv | 73 +++++++
 rtl/shr_pipe.sv | 88 ++++++++
 tb/tb_shr_pipe.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shr_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and a
// constant-evaluable ceil(log2) helper for sizing the shift-amount path.
package shr_pkg;

    typedef enum logic [1:0] {
        MODE_SHRL = 2'b00,
        MODE_SHRA = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_ROR  = 2'b11
    } shr_mode_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/shr_pipe_if.sv
// Input and output handshake bundle of shr_pipe; master is the traffic side,
// slave is the shifter.
interface shr_pipe_if #(
    parameter int DATAWIDTH = 8,
    parameter int SHWIDTH   = DATAWIDTH
);
    // Handshake: a beat moves on a rising clock edge exactly when valid and
    // ready are both high; valid never waits on ready, and a producer holding
    // valid keeps its payload stable until that transfer happens.
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] a;
    logic [SHWIDTH-1:0]   sh_amt;
    logic [1:0]           mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATAWIDTH-1:0] d;
    logic                 ovf;

    modport master (
        output in_valid, a, sh_amt, mode, out_ready,
        input  in_ready, out_valid, d, ovf
    );

    modport slave (
        input  in_valid, a, sh_amt, mode, out_ready,
        output in_ready, out_valid, d, ovf
    );
endinterface

// File: rtl/shr_pipe_stage.sv
// One registered group of right-shift/rotate mux levels with its own valid bit.
// The last stage also undoes the left-shift bit reversal and applies over-range.
module shr_pipe_stage
    import shr_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int AMTW      = 3,
    parameter int FIRST_LVL = 0,
    parameter int NUM_LVL   = 3,
    parameter bit LAST      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up_valid,
    input  logic                 down_ready,
    output logic                 load,
    output logic                 valid,
    input  logic [DATAWIDTH-1:0] up_data,
    input  logic [AMTW-1:0]      up_amt,
    input  shr_mode_e            up_mode,
    input  logic                 up_ovf,
    input  logic                 up_fill,
    output logic [DATAWIDTH-1:0] data,
    output logic [AMTW-1:0]      amt,
    output shr_mode_e            mode,
    output logic                 ovf,
    output logic                 fill
);

    logic [DATAWIDTH-1:0] lv [NUM_LVL+1];
    logic [DATAWIDTH-1:0] res;

    assign lv[0] = up_data;

    for (genvar j = 0; j < NUM_LVL; j++) begin : g_lvl
        localparam int SH = 1 << (FIRST_LVL + j);
        assign lv[j+1] = !up_amt[FIRST_LVL+j]  ? lv[j] :
                         (up_mode == MODE_ROR) ? {lv[j][SH-1:0], lv[j][DATAWIDTH-1:SH]} :
                                                 {{SH{up_fill}}, lv[j][DATAWIDTH-1:SH]};
    end

    always_comb begin
        res = lv[NUM_LVL];
        if (LAST && up_mode == MODE_SHL) begin
            for (int i = 0; i < DATAWIDTH; i++) res[i] = lv[NUM_LVL][DATAWIDTH-1-i];
        end
        // Over-range result is pure fill: zero, or the sign for arithmetic shifts.
        if (LAST && up_ovf) res = {DATAWIDTH{up_fill}};
    end

    assign load = !valid || down_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
            amt   <= '0;
            mode  <= MODE_SHRL;
            ovf   <= 1'b0;
            fill  <= 1'b0;
        end else if (load) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= res;
                amt  <= up_amt;
                mode <= up_mode;
                ovf  <= up_ovf;
                fill <= up_fill;
            end
        end
    end

endmodule

// File: rtl/shr_pipe.sv
// Pipelined barrel shifter: logical/arithmetic right, left (via bit reversal
// around the right-shift core) and rotate-right, with valid/ready on both sides.
module shr_pipe
    import shr_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int SHWIDTH   = DATAWIDTH,
    parameter int STAGES    = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    shr_pipe_if.slave  bus
);

    localparam int L = clog2(DATAWIDTH);
    localparam int G = (L + STAGES - 1) / STAGES;

    shr_mode_e            head_mode;
    logic [DATAWIDTH-1:0] head_data;
    logic [L-1:0]         head_amt;
    logic                 head_ovf;
    logic                 head_fill;

    logic [DATAWIDTH-1:0] s_data  [STAGES+1];
    logic [L-1:0]         s_amt   [STAGES+1];
    shr_mode_e            s_mode  [STAGES+1];
    logic                 s_ovf   [STAGES+1];
    logic                 s_fill  [STAGES+1];
    logic                 s_valid [STAGES+1];
    logic                 s_rdy   [STAGES+1];

    assign head_mode = shr_mode_e'(bus.mode);
    assign head_amt  = bus.sh_amt[L-1:0];
    // Over-range is decided once here; rotate only ever uses the low L bits.
    assign head_ovf  = (head_mode != MODE_ROR) && ((bus.sh_amt >> L) != '0);
    assign head_fill = (head_mode == MODE_SHRA) && bus.a[DATAWIDTH-1];

    always_comb begin
        head_data = bus.a;
        if (head_mode == MODE_SHL) begin
            for (int i = 0; i < DATAWIDTH; i++) head_data[i] = bus.a[DATAWIDTH-1-i];
        end
    end

    assign s_data[0]  = head_data;
    assign s_amt[0]   = head_amt;
    assign s_mode[0]  = head_mode;
    assign s_ovf[0]   = head_ovf;
    assign s_fill[0]  = head_fill;
    assign s_valid[0] = bus.in_valid;
    assign s_rdy[STAGES] = bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int FIRST = k * G;
        localparam int NUM   = (FIRST >= L) ? 0 : ((L - FIRST < G) ? (L - FIRST) : G);

        shr_pipe_stage #(
            .DATAWIDTH (DATAWIDTH),
            .AMTW      (L),
            .FIRST_LVL (FIRST),
            .NUM_LVL   (NUM),
            .LAST      (k == STAGES - 1)
        ) u_stage (
            .clk        (Clk),
            .rst        (Rst),
            .up_valid   (s_valid[k]),
            .down_ready (s_rdy[k+1]),
            .load       (s_rdy[k]),
            .valid      (s_valid[k+1]),
            .up_data    (s_data[k]),
            .up_amt     (s_amt[k]),
            .up_mode    (s_mode[k]),
            .up_ovf     (s_ovf[k]),
            .up_fill    (s_fill[k]),
            .data       (s_data[k+1]),
            .amt        (s_amt[k+1]),
            .mode       (s_mode[k+1]),
            .ovf        (s_ovf[k+1]),
            .fill       (s_fill[k+1])
        );
    end

    assign bus.in_ready  = s_rdy[0] && Rst;
    assign bus.out_valid = s_valid[STAGES];
    assign bus.d         = s_data[STAGES];
    assign bus.ovf       = s_ovf[STAGES];

endmodule

// File: tb/tb_shr_pipe.sv
// Directed and streamed checks of shr_pipe at 8 bits/1 stage and 32 bits/5 stages.
module tb_shr_pipe;
    import shr_pkg::*;

    int tests_run    = 0;
    int tests_failed = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shr_pipe_if #(.DATAWIDTH(8),  .SHWIDTH(8))  bus8 ();
    shr_pipe_if #(.DATAWIDTH(32), .SHWIDTH(32)) bus32 ();

    shr_pipe #(.DATAWIDTH(8), .SHWIDTH(8), .STAGES(1)) u_dut8 (
        .Clk (clk),
        .Rst (rst),
        .bus (bus8)
    );

    shr_pipe #(.DATAWIDTH(32), .SHWIDTH(32), .STAGES(5)) u_dut32 (
        .Clk (clk),
        .Rst (rst),
        .bus (bus32)
    );

    logic [32:0] exp_q[$];

    function automatic logic [32:0] model32(input logic [31:0] a, input logic [31:0] amt,
                                            input logic [1:0] mode);
        logic [63:0] dbl;
        logic [31:0] r;
        logic        o;
        o = 1'b0;
        r = '0;
        case (mode)
            2'b00: if (amt >= 32) o = 1'b1; else r = a >> amt;
            2'b01: if (amt >= 32) begin o = 1'b1; r = {32{a[31]}}; end
                   else r = $unsigned($signed(a) >>> amt);
            2'b10: if (amt >= 32) o = 1'b1; else r = a << amt;
            default: begin
                dbl = {a, a} >> (amt % 32);
                r   = dbl[31:0];
            end
        endcase
        return {o, r};
    endfunction

    // Drives one beat into the 8-bit DUT and samples its outputs one cycle later.
    task automatic send8(input logic [7:0] a, input logic [7:0] amt, input logic [1:0] mode,
                         output logic rdy, output logic v, output logic o, output logic [7:0] d);
        @(posedge clk); #1;
        bus8.in_valid  = 1'b1;
        bus8.a         = a;
        bus8.sh_amt    = amt;
        bus8.mode      = mode;
        bus8.out_ready = 1'b1;
        #1;
        rdy = bus8.in_ready;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        v = bus8.out_valid;
        o = bus8.ovf;
        d = bus8.d;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({bus8.out_valid, bus8.ovf, bus8.d} !== 10'h0) begin
            tests_failed++;
            $display("FAIL reset8_outputs: got valid=%b ovf=%b d=%h, want 0 0 00",
                     bus8.out_valid, bus8.ovf, bus8.d);
        end
        tests_run++;
        if ({bus32.out_valid, bus32.ovf, bus32.d} !== 34'h0) begin
            tests_failed++;
            $display("FAIL reset32_outputs: got valid=%b ovf=%b d=%h, want 0 0 0",
                     bus32.out_valid, bus32.ovf, bus32.d);
        end
        tests_run++;
        if ({bus8.in_ready, bus32.in_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_in_ready_low: got %b%b, want 00", bus8.in_ready, bus32.in_ready);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({bus8.in_ready, bus32.in_ready} !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_in_ready_high: got %b%b, want 11", bus8.in_ready, bus32.in_ready);
        end
    endtask

    task automatic test_shift_right();
        logic r, v, o;
        logic [7:0] d;
        send8(8'hB4, 8'd3, MODE_SHRL, r, v, o, d);
        tests_run++;
        if ({r, v, o, d} !== {1'b1, 1'b1, 1'b0, 8'h16}) begin
            tests_failed++;
            $display("FAIL shrl_b4_3: got rdy=%b v=%b ovf=%b d=%h, want 1 1 0 16", r, v, o, d);
        end
        send8(8'hB4, 8'd3, MODE_SHRA, r, v, o, d);
        tests_run++;
        if ({r, v, o, d} !== {1'b1, 1'b1, 1'b0, 8'hF6}) begin
            tests_failed++;
            $display("FAIL shra_b4_3: got rdy=%b v=%b ovf=%b d=%h, want 1 1 0 f6", r, v, o, d);
        end
        send8(8'h4C, 8'd7, MODE_SHRA, r, v, o, d);
        tests_run++;
        if ({v, o, d} !== {1'b1, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL shra_4c_7: got v=%b ovf=%b d=%h, want 1 0 00", v, o, d);
        end
    endtask

    task automatic test_shift_left_rotate();
        logic r, v, o;
        logic [7:0] d;
        send8(8'h81, 8'd1, MODE_SHL, r, v, o, d);
        tests_run++;
        if ({v, o, d} !== {1'b1, 1'b0, 8'h02}) begin
            tests_failed++;
            $display("FAIL shl_81_1: got v=%b ovf=%b d=%h, want 1 0 02", v, o, d);
        end
        send8(8'h81, 8'd1, MODE_ROR, r, v, o, d);
        tests_run++;
        if ({v, o, d} !== {1'b1, 1'b0, 8'hC0}) begin
            tests_failed++;
            $display("FAIL ror_81_1: got v=%b ovf=%b d=%h, want 1 0 c0", v, o, d);
        end
        send8(8'h81, 8'd9, MODE_ROR, r, v, o, d);
        tests_run++;
        if ({v, o, d} !== {1'b1, 1'b0, 8'hC0}) begin
            tests_failed++;
            $display("FAIL ror_81_9: got v=%b ovf=%b d=%h, want 1 0 c0", v, o, d);
        end
        send8(8'h96, 8'd5, MODE_SHL, r, v, o, d);
        tests_run++;
        if ({v, o, d} !== {1'b1, 1'b0, 8'hC0}) begin
            tests_failed++;
            $display("FAIL shl_96_5: got v=%b ovf=%b d=%h, want 1 0 c0", v, o, d);
        end
        send8(8'h96, 8'd3, MODE_ROR, r, v, o, d);
        tests_run++;
        if ({v, o, d} !== {1'b1, 1'b0, 8'hD2}) begin
            tests_failed++;
            $display("FAIL ror_96_3: got v=%b ovf=%b d=%h, want 1 0 d2", v, o, d);
        end
    endtask

    task automatic test_overrange();
        logic r, v, o;
        logic [7:0] d;
        send8(8'h80, 8'd8, MODE_SHRA, r, v, o, d);
        tests_run++;
        if ({v, o, d} !== {1'b1, 1'b1, 8'hFF}) begin
            tests_failed++;
            $display("FAIL ovr_shra_80_8: got v=%b ovf=%b d=%h, want 1 1 ff", v, o, d);
        end
        send8(8'h80, 8'd8, MODE_SHRL, r, v, o, d);
        tests_run++;
        if ({v, o, d} !== {1'b1, 1'b1, 8'h00}) begin
            tests_failed++;
            $display("FAIL ovr_shrl_80_8: got v=%b ovf=%b d=%h, want 1 1 00", v, o, d);
        end
        send8(8'hFF, 8'd200, MODE_SHL, r, v, o, d);
        tests_run++;
        if ({v, o, d} !== {1'b1, 1'b1, 8'h00}) begin
            tests_failed++;
            $display("FAIL ovr_shl_ff_200: got v=%b ovf=%b d=%h, want 1 1 00", v, o, d);
        end
        send8(8'h7F, 8'd16, MODE_SHRA, r, v, o, d);
        tests_run++;
        if ({v, o, d} !== {1'b1, 1'b1, 8'h00}) begin
            tests_failed++;
            $display("FAIL ovr_shra_7f_16: got v=%b ovf=%b d=%h, want 1 1 00", v, o, d);
        end
        send8(8'h5A, 8'd8, MODE_ROR, r, v, o, d);
        tests_run++;
        if ({v, o, d} !== {1'b1, 1'b0, 8'h5A}) begin
            tests_failed++;
            $display("FAIL ror_5a_8: got v=%b ovf=%b d=%h, want 1 0 5a", v, o, d);
        end
    endtask

    task automatic test_zero_amount();
        logic r, v, o;
        logic [7:0] d;
        for (int m = 0; m < 4; m++) begin
            send8(8'hA5, 8'd0, m[1:0], r, v, o, d);
            tests_run++;
            if ({v, o, d} !== {1'b1, 1'b0, 8'hA5}) begin
                tests_failed++;
                $display("FAIL zero_amt_mode%0d: got v=%b ovf=%b d=%h, want 1 0 a5", m, v, o, d);
            end
        end
    endtask

    task automatic test_stream_stall();
        logic [32:0] e;
        logic        want_rdy;
        exp_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            bus32.in_valid  = 1'($urandom_range(0, 1));
            bus32.a         = $urandom;
            bus32.sh_amt    = 32'($urandom_range(0, 40));
            bus32.mode      = 2'($urandom_range(0, 3));
            bus32.out_ready = 1'($urandom_range(0, 1));
            #1;
            want_rdy = !(exp_q.size() == 5 && !bus32.out_ready);
            tests_run++;
            if (bus32.in_ready !== want_rdy) begin
                tests_failed++;
                $display("FAIL stream_in_ready cyc %0d: got %b, want %b (in flight %0d)",
                         cyc, bus32.in_ready, want_rdy, exp_q.size());
            end
            if (bus32.out_valid === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL stream_extra_output cyc %0d: got d=%h, want no output", cyc, bus32.d);
                end else if ({bus32.ovf, bus32.d} !== exp_q[0]) begin
                    tests_failed++;
                    $display("FAIL stream_data cyc %0d: got %h, want %h", cyc, {bus32.ovf, bus32.d}, exp_q[0]);
                end
                if (bus32.out_ready && exp_q.size() != 0) e = exp_q.pop_front();
            end
            if (bus32.in_valid && bus32.in_ready)
                exp_q.push_back(model32(bus32.a, bus32.sh_amt, bus32.mode));
        end
        @(posedge clk); #1;
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (bus32.out_valid === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL drain_extra_output: got d=%h, want no output", bus32.d);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus32.ovf, bus32.d} !== e) begin
                        tests_failed++;
                        $display("FAIL drain_data: got %h, want %h", {bus32.ovf, bus32.d}, e);
                    end
                end
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (exp_q.size() != 0 || bus32.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_lost: got %0d undelivered, out_valid=%b, want 0 and 0",
                     exp_q.size(), bus32.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] e;
        int first = -1;
        int last  = -1;
        int got   = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            bus32.in_valid  = (cyc < 20);
            bus32.a         = 32'hF000_000F + 32'(cyc) * 32'h0101_0101;
            bus32.sh_amt    = 32'(cyc + 3);
            bus32.mode      = 2'(cyc % 4);
            bus32.out_ready = 1'b1;
            #1;
            if (bus32.in_valid) begin
                tests_run++;
                if (bus32.in_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_in_ready cyc %0d: got %b, want 1", cyc, bus32.in_ready);
                end
                exp_q.push_back(model32(bus32.a, bus32.sh_amt, bus32.mode));
            end
            if (bus32.out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                last = cyc;
                got++;
                e = exp_q.pop_front();
                tests_run++;
                if ({bus32.ovf, bus32.d} !== e) begin
                    tests_failed++;
                    $display("FAIL b2b_data cyc %0d: got %h, want %h", cyc, {bus32.ovf, bus32.d}, e);
                end
            end
        end
        bus32.in_valid = 1'b0;
        tests_run++;
        if (first != 5 || last != 24 || got != 20) begin
            tests_failed++;
            $display("FAIL b2b_timing: got first=%0d last=%0d count=%0d, want 5 24 20", first, last, got);
        end
    endtask

    task automatic test_reset_midflight();
        logic [32:0] e;
        int first = -1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus32.in_valid  = 1'b1;
            bus32.a         = 32'h1234_5678 + 32'(i);
            bus32.sh_amt    = 32'd4;
            bus32.mode      = MODE_SHRL;
            bus32.out_ready = 1'b0;
        end
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({bus32.out_valid, bus32.ovf, bus32.d} !== 34'h0 || bus32.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_clear: got valid=%b ovf=%b d=%h in_ready=%b, want 0 0 0 0",
                     bus32.out_valid, bus32.ovf, bus32.d, bus32.in_ready);
        end
        rst = 1'b1;
        bus32.out_ready = 1'b1;
        #1;
        tests_run++;
        if (bus32.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_in_ready: got %b, want 1", bus32.in_ready);
        end
        bus32.in_valid = 1'b1;
        bus32.a        = 32'h8000_1234;
        bus32.sh_amt   = 32'd8;
        bus32.mode     = MODE_SHRA;
        e = 33'h0_FF80_0012;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            bus32.in_valid = 1'b0;
            if (bus32.out_valid === 1'b1 && first < 0) begin
                first = cyc;
                tests_run++;
                if ({bus32.ovf, bus32.d} !== e) begin
                    tests_failed++;
                    $display("FAIL midreset_data: got %h, want %h", {bus32.ovf, bus32.d}, e);
                end
            end
        end
        tests_run++;
        if (first != 5) begin
            tests_failed++;
            $display("FAIL midreset_latency: got first output at %0d, want 5", first);
        end
    endtask

    initial begin
        bus8.in_valid   = 1'b0;
        bus8.a          = '0;
        bus8.sh_amt     = '0;
        bus8.mode       = 2'b00;
        bus8.out_ready  = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.a         = '0;
        bus32.sh_amt    = '0;
        bus32.mode      = 2'b00;
        bus32.out_ready = 1'b1;

        test_reset();
        test_shift_right();
        test_shift_left_rotate();
        test_overrange();
        test_zero_amount();
        test_stream_stall();
        test_back_to_back();
        test_reset_midflight();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
